in_service_control_8259a: RTL
=============================

Name: in_service_control_8259a

Overview:
- Downstream neighbour of the priority resolver in the 8259A core.
- Consumes the resolver's one-hot `interrupt` and latches it into the In-Service Register (ISR) on the acknowledge-sequence strobe.
- Executes EOI commands (specific, non-specific, automatic) and maintains the rotation pointer.
- Feeds `in_service_register`, `highest_level_in_service` and `priority_rotate` back to the resolver, and supplies the acknowledged level to vector generation.

Parameters:
- None. The 8 interrupt levels and the 3-bit level encoding are fixed by the 8259A architecture.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- interrupt  in  8  one-hot (or zero) highest pending request from the priority resolver
- latch_in_service  in  1  single-cycle strobe, first INTA of the acknowledge sequence
- end_of_ack_sequence  in  1  single-cycle strobe, last INTA of the acknowledge sequence
- auto_eoi_config  in  1  ICW4 AEOI mode
- auto_rotate_mode  in  1  rotate-on-AEOI enable (OCW2 R with AEOI)
- nonspecific_eoi  in  1  single-cycle OCW2 non-specific EOI strobe
- specific_eoi  in  1  single-cycle OCW2 specific EOI strobe
- rotate_on_eoi  in  1  qualifies either EOI strobe with rotation
- set_priority  in  1  single-cycle OCW2 set-priority strobe, no EOI
- command_level  in  3  level L from OCW2, used by specific EOI and set-priority
- in_service_register  out  8  ISR contents
- highest_level_in_service  out  8  one-hot highest-priority set ISR bit under current rotation; 0 if ISR empty
- priority_rotate  out  3  lowest-priority level; highest priority is (priority_rotate+1) mod 8
- ack_level  out  3  encoded level latched at the last latch_in_service
- ack_valid  out  1  high from latch_in_service until end_of_ack_sequence

Behaviour:
- Reset values:
  - in_service_register = 8'h00
  - priority_rotate = 3'd7, so IR0 is highest
  - ack_level = 3'd0
  - ack_valid = 0
  - highest_level_in_service = 8'h00 (combinational)
- Reset is asynchronous. Asserting it mid-sequence drops any in-flight acknowledge; no partial state survives.
- All registered outputs update on the clock edge after the strobe (1-cycle latency). highest_level_in_service is combinational from the registered ISR and priority_rotate (0-cycle).
- highest_level_in_service search: scan levels (priority_rotate+1) mod 8 upward, wrapping; the first set ISR bit is reported.
- latch_in_service:
  - ISR |= interrupt.
  - ack_level = encode(interrupt); ack_valid = 1.
  - If interrupt == 0 (spurious): ISR unchanged, ack_level = 7, ack_valid = 1.
- end_of_ack_sequence:
  - ack_valid = 0.
  - If auto_eoi_config: clear ISR[ack_level].
  - If auto_eoi_config && auto_rotate_mode: also priority_rotate = ack_level.
  - Ignored when ack_valid = 0.
- nonspecific_eoi:
  - Clear the bit in highest_level_in_service.
  - If rotate_on_eoi: priority_rotate = encode(that bit).
  - If ISR is empty: no change, rotation included.
- specific_eoi:
  - Clear ISR[command_level], even if already 0.
  - If rotate_on_eoi: priority_rotate = command_level.
- set_priority: priority_rotate = command_level; ISR unchanged.
- Precedence when strobes coincide in one cycle:
  - Clears: all requested clears apply (specific, non-specific, AEOI), each evaluated against the pre-edge ISR.
  - Latch vs clear: the latch OR is applied after the clears, so a new bit survives a same-cycle clear of the same level.
  - Rotation source: specific_eoi > nonspecific_eoi > AEOI > set_priority.
  - A latch_in_service and end_of_ack_sequence in the same cycle is illegal; behaviour is "latch wins, end ignored".
- Width rules:
  - Level arithmetic is modulo 8 (3-bit wrap).
  - encode() of a one-hot vector returns the index of the set bit.
  - No multi-bit ISR insertion occurs because the input is one-hot by contract.

Test Plan:
1. Reset → ISR=00, priority_rotate=7, highest_level_in_service=00, ack_valid=0.
2. interrupt=8'h08, latch_in_service pulse, then end_of_ack_sequence with AEOI off → ISR=08, ack_level=3, ack_valid 1→0; then nonspecific_eoi → ISR=00.
3. ISR=8'h24, priority_rotate=7 → highest=04. Then specific_eoi with rotate_on_eoi, command_level=2 → ISR=20, priority_rotate=2, highest=20.
4. AEOI + auto_rotate on, interrupt=8'h40 acknowledged → after end_of_ack_sequence ISR=00, priority_rotate=6. Next request set 8'h81 → resolver sees IR7 highest.
5. ISR=8'h01, latch_in_service with interrupt=8'h01 plus specific_eoi on level 0 in the same cycle → ISR=01. Set_priority(L=4) plus nonspecific_eoi with rotate in the same cycle → priority_rotate=0.
6. Assert reset while ack_valid=1 and ISR=8'hFF → all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/in_service_control_8259a.sv
// In-service control for the 8259A core: holds the ISR, executes EOI commands,
// tracks the rotation pointer and reports the acknowledged level.
module in_service_control_8259a (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       latch_in_service,
  input  logic       end_of_ack_sequence,
  input  logic       auto_eoi_config,
  input  logic       auto_rotate_mode,
  input  logic       nonspecific_eoi,
  input  logic       specific_eoi,
  input  logic       rotate_on_eoi,
  input  logic       set_priority,
  input  logic [2:0] command_level,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [2:0] ack_level,
  output logic       ack_valid
);

  function automatic logic [2:0] encode(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Scan upward from the highest-priority level, wrapping modulo 8.
  function automatic logic [7:0] find_highest(input logic [7:0] isr_v, input logic [2:0] rot);
    logic [7:0] res;
    logic [2:0] lvl;
    logic       found;
    res   = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lvl = rot + 3'd1 + 3'(i);
      if (!found && isr_v[lvl]) begin
        res[lvl] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] level_mask(input logic [2:0] lvl);
    logic [7:0] m;
    m      = 8'h00;
    m[lvl] = 1'b1;
    return m;
  endfunction

  logic [7:0] isr_next;
  logic [2:0] rotate_next;
  logic [2:0] ack_level_next;
  logic       ack_valid_next;
  logic       end_effective;
  logic       aeoi_clear;
  logic [7:0] clear_mask;

  assign highest_level_in_service = find_highest(in_service_register, priority_rotate);

  // A same-cycle latch suppresses the end strobe; an end outside a sequence is ignored.
  assign end_effective = end_of_ack_sequence && ack_valid && !latch_in_service;
  assign aeoi_clear    = end_effective && auto_eoi_config;

  always_comb begin
    clear_mask     = 8'h00;
    rotate_next    = priority_rotate;
    ack_level_next = ack_level;
    ack_valid_next = ack_valid;

    // Every clear is taken against the pre-edge ISR; the latch OR goes last.
    if (specific_eoi)    clear_mask = clear_mask | level_mask(command_level);
    if (nonspecific_eoi) clear_mask = clear_mask | highest_level_in_service;
    if (aeoi_clear)      clear_mask = clear_mask | level_mask(ack_level);
    isr_next = in_service_register & ~clear_mask;
    if (latch_in_service) isr_next = isr_next | interrupt;

    if (specific_eoi && rotate_on_eoi)
      rotate_next = command_level;
    else if (nonspecific_eoi && rotate_on_eoi && (in_service_register != 8'h00))
      rotate_next = encode(highest_level_in_service);
    else if (aeoi_clear && auto_rotate_mode)
      rotate_next = ack_level;
    else if (set_priority)
      rotate_next = command_level;

    // An empty interrupt vector is a spurious acknowledge, reported as level 7.
    if (latch_in_service) begin
      ack_level_next = (interrupt == 8'h00) ? 3'd7 : encode(interrupt);
      ack_valid_next = 1'b1;
    end else if (end_effective) begin
      ack_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_service_register <= 8'h00;
      priority_rotate     <= 3'd7;
      ack_level           <= 3'd0;
      ack_valid           <= 1'b0;
    end else begin
      in_service_register <= isr_next;
      priority_rotate     <= rotate_next;
      ack_level           <= ack_level_next;
      ack_valid           <= ack_valid_next;
    end
  end

endmodule
